// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned LOAD_LAT_MAX    = 4;
    localparam int unsigned FLUSH_DEPTH_MAX = 3;

    // Largest value the sequencing counter ever holds (LAT-1 or DEPTH-1).
    localparam int unsigned SEQ_MAX   = (LOAD_LAT_MAX > FLUSH_DEPTH_MAX) ?
                                        (LOAD_LAT_MAX - 1) : (FLUSH_DEPTH_MAX - 1);
    localparam int unsigned SEQ_CNT_W = $clog2(SEQ_MAX + 1);

    typedef enum logic [1:0] {
        StRun,
        StLstall,
        StFlush,
        StHalt
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic [REG_W-1:0] id_ex_rt;
    logic             id_ex_mem_read;
    logic             pc_src;
    logic             brk;
    logic             resume;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_rt, id_ex_mem_read,
               pc_src, brk, resume,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble,
               halted, stall_cycles
    );

    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_rt, id_ex_mem_read,
               pc_src, brk, resume,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble,
               halted, stall_cycles
    );

endinterface

// File: rtl/sat_counter.sv
// Enable-driven up counter that sticks at its all-ones value.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, redirect flush and break/halt control for a 5-stage pipeline.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned CNT_W       = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);

    localparam logic [SEQ_CNT_W-1:0] LSTALL_INIT = SEQ_CNT_W'(LOAD_LAT - 1);
    localparam logic [SEQ_CNT_W-1:0] FLUSH_INIT  = SEQ_CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [SEQ_CNT_W-1:0] CNT_ONE     = SEQ_CNT_W'(1);

    state_e               r_state;
    logic [SEQ_CNT_W-1:0] r_cnt;

    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic [REG_W-1:0] w_ex_rt;
    logic             w_hazard;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic             w_ex_mem_bubble;
    logic             w_halted;
    logic             w_cnt_en;

    assign w_rs    = bus.if_id_rs;
    assign w_rt    = bus.if_id_rt;
    assign w_ex_rt = bus.id_ex_rt;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign w_hazard = bus.id_ex_mem_read & (w_ex_rt != '0) &
                      ((w_ex_rt == w_rs) | (bus.if_id_uses_rt & (w_ex_rt == w_rt)));

    // State and sequencing counter; brk outranks redirect, redirect abandons a load stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                StRun, StLstall: begin
                    if (bus.brk) begin
                        r_state <= StHalt;
                        r_cnt   <= '0;
                    end else if (bus.pc_src) begin
                        r_state <= (FLUSH_DEPTH > 1) ? StFlush : StRun;
                        r_cnt   <= (FLUSH_DEPTH > 1) ? FLUSH_INIT : '0;
                    end else if (r_state == StLstall) begin
                        if (r_cnt <= CNT_ONE) begin
                            r_state <= StRun;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end else if (w_hazard && (LOAD_LAT > 1)) begin
                        r_state <= StLstall;
                        r_cnt   <= LSTALL_INIT;
                    end
                end
                StFlush: begin
                    if (bus.brk) begin
                        r_state <= StHalt;
                        r_cnt   <= '0;
                    end else if (bus.pc_src) begin
                        r_cnt <= FLUSH_INIT;
                    end else if (r_cnt <= CNT_ONE) begin
                        r_state <= StRun;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                StHalt: begin
                    if (bus.resume) begin
                        r_state <= StRun;
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Pipeline controls decoded from state and current inputs; reset forces a full squash.
    always_comb begin
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_halted        = 1'b0;
        if (rst) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_bubble = 1'b1;
        end else begin
            unique case (r_state)
                StRun, StLstall: begin
                    if (bus.brk || bus.pc_src) begin
                        w_pc_write      = ~bus.brk;
                        w_if_id_write   = 1'b0;
                        w_if_id_flush   = 1'b1;
                        w_id_ex_bubble  = 1'b1;
                        w_ex_mem_bubble = 1'b1;
                    end else if ((r_state == StLstall) || w_hazard) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                    end
                end
                StFlush: begin
                    w_pc_write      = ~bus.brk;
                    w_if_id_write   = 1'b0;
                    w_if_id_flush   = 1'b1;
                    w_id_ex_bubble  = 1'b1;
                    w_ex_mem_bubble = bus.brk;
                end
                StHalt: begin
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_halted       = 1'b1;
                end
                default: begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                end
            endcase
        end
    end

    assign w_cnt_en = ~w_pc_write & (r_state != StHalt) & ~rst;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cnt_en),
        .o_count (bus.stall_cycles)
    );

    assign bus.pc_write      = w_pc_write;
    assign bus.if_id_write   = w_if_id_write;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_bubble  = w_id_ex_bubble;
    assign bus.ex_mem_bubble = w_ex_mem_bubble;
    assign bus.halted        = w_halted;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven in lockstep against a pending-work model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic       mem_read;
        logic       pc_src;
        logic       brk;
        logic       resume;
    } in_t;

    // Model tracks remaining stall/flush work instead of FSM states.
    typedef struct {
        int lat;
        int depth;
        int maxc;
        int stall_left;
        int flush_left;
        bit halt;
        int stalls;
    } model_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;
    } vec_t;

    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble, halted}
    localparam logic [5:0] O_IDLE  = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_REDIR = 6'b101110;
    localparam logic [5:0] O_FLUSH = 6'b101100;
    localparam logic [5:0] O_BRK   = 6'b001110;
    localparam logic [5:0] O_HALT  = 6'b000101;
    localparam logic [5:0] O_RST   = 6'b001110;

    logic clk = 1'b0;
    logic rst;
    in_t  cur;
    int   total = 0;
    int   bad = 0;
    int   low_a, low_b, bub_b, flush_b, flushpc_b;
    model_t ma, mb;
    vec_t tbl[10];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus_a ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  bus_b ();

    assign bus_a.if_id_rs       = cur.rs;
    assign bus_a.if_id_rt       = cur.rt;
    assign bus_a.if_id_uses_rt  = cur.uses_rt;
    assign bus_a.id_ex_rt       = cur.ex_rt;
    assign bus_a.id_ex_mem_read = cur.mem_read;
    assign bus_a.pc_src         = cur.pc_src;
    assign bus_a.brk            = cur.brk;
    assign bus_a.resume         = cur.resume;
    assign bus_b.if_id_rs       = cur.rs;
    assign bus_b.if_id_rt       = cur.rt;
    assign bus_b.if_id_uses_rt  = cur.uses_rt;
    assign bus_b.id_ex_rt       = cur.ex_rt;
    assign bus_b.id_ex_mem_read = cur.mem_read;
    assign bus_b.pc_src         = cur.pc_src;
    assign bus_b.brk            = cur.brk;
    assign bus_b.resume         = cur.resume;

    hazard_ctrl #(
        .REG_W(5), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    hazard_ctrl #(
        .REG_W(5), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    function automatic in_t mk(int rs, int rt, bit u, int ex, bit mr, bit pc, bit bk, bit rs_m);
        in_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.uses_rt = u; i.ex_rt = 5'(ex);
        i.mem_read = mr; i.pc_src = pc; i.brk = bk; i.resume = rs_m;
        return i;
    endfunction

    function automatic bit is_hazard(in_t i);
        return i.mem_read && (i.ex_rt != 0) &&
               ((i.ex_rt == i.rs) || (i.uses_rt && (i.ex_rt == i.rt)));
    endfunction

    function automatic logic [5:0] model_out(model_t m, in_t i, logic r);
        if (r) return O_RST;
        if (m.halt) return O_HALT;
        if (i.brk) return O_BRK;
        if (m.flush_left > 0) return O_FLUSH;
        if (i.pc_src) return O_REDIR;
        if ((m.stall_left > 0) || is_hazard(i)) return O_STALL;
        return O_IDLE;
    endfunction

    function automatic model_t model_step(model_t m, in_t i, logic r);
        logic [5:0] o;
        o = model_out(m, i, r);
        if (r) begin
            m.stall_left = 0; m.flush_left = 0; m.halt = 1'b0; m.stalls = 0;
            return m;
        end
        if (!o[5] && !m.halt && (m.stalls < m.maxc)) m.stalls++;
        if (m.halt) begin
            if (i.resume) m.halt = 1'b0;
        end else if (i.brk) begin
            m.halt = 1'b1; m.stall_left = 0; m.flush_left = 0;
        end else if (m.flush_left > 0) begin
            m.flush_left = i.pc_src ? (m.depth - 1) : (m.flush_left - 1);
        end else if (i.pc_src) begin
            m.flush_left = m.depth - 1; m.stall_left = 0;
        end else if (m.stall_left > 0) begin
            m.stall_left--;
        end else if (is_hazard(i)) begin
            m.stall_left = m.lat - 1;
        end
        return m;
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs_a();
        return {bus_a.pc_write, bus_a.if_id_write, bus_a.if_id_flush,
                bus_a.id_ex_bubble, bus_a.ex_mem_bubble, bus_a.halted};
    endfunction

    function automatic logic [5:0] outs_b();
        return {bus_b.pc_write, bus_b.if_id_write, bus_b.if_id_flush,
                bus_b.id_ex_bubble, bus_b.ex_mem_bubble, bus_b.halted};
    endfunction

    task automatic check_models(string tag);
        compare({tag, "_a_out"}, 32'(outs_a()), 32'(model_out(ma, cur, rst)));
        compare({tag, "_b_out"}, 32'(outs_b()), 32'(model_out(mb, cur, rst)));
        compare({tag, "_a_cnt"}, 32'(bus_a.stall_cycles), rst ? 32'd0 : 32'(ma.stalls));
        compare({tag, "_b_cnt"}, 32'(bus_b.stall_cycles), rst ? 32'd0 : 32'(mb.stalls));
    endtask

    // Called just after a rising edge: settle, check, then advance to the next edge.
    task automatic cycle(string tag);
        #2;
        check_models(tag);
        if (!bus_a.pc_write) low_a++;
        if (!bus_b.pc_write) low_b++;
        if (bus_b.id_ex_bubble) bub_b++;
        if (bus_b.if_id_flush) flush_b++;
        if (bus_b.if_id_flush && bus_b.pc_write) flushpc_b++;
        @(posedge clk);
        ma = model_step(ma, cur, rst);
        mb = model_step(mb, cur, rst);
        #1;
    endtask

    task automatic clear_tallies();
        low_a = 0; low_b = 0; bub_b = 0; flush_b = 0; flushpc_b = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst");
        rst = 1'b0;
        clear_tallies();
    endtask

    initial begin
        ma = '{lat: 1, depth: 1, maxc: 65535, stall_left: 0, flush_left: 0, halt: 0, stalls: 0};
        mb = '{lat: 3, depth: 2, maxc: 15, stall_left: 0, flush_left: 0, halt: 0, stalls: 0};
        rst = 1'b1;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        compare("reset_out_a", 32'(outs_a()), 32'(O_RST));
        compare("reset_cnt_b", 32'(bus_b.stall_cycles), 32'd0);
        @(posedge clk);
        ma = model_step(ma, cur, rst);
        mb = model_step(mb, cur, rst);
        #1;
        rst = 1'b0;
        clear_tallies();

        // Decode table for the LOAD_LAT=1 / FLUSH_DEPTH=1 instance, which stays in RUN.
        tbl[0] = '{mk(1, 2, 1, 3, 1, 0, 0, 0), O_IDLE};
        tbl[1] = '{mk(5, 2, 0, 5, 1, 0, 0, 0), O_STALL};
        tbl[2] = '{mk(1, 7, 1, 7, 1, 0, 0, 0), O_STALL};
        tbl[3] = '{mk(1, 7, 0, 7, 1, 0, 0, 0), O_IDLE};
        tbl[4] = '{mk(0, 0, 1, 0, 1, 0, 0, 0), O_IDLE};
        tbl[5] = '{mk(5, 5, 1, 5, 0, 0, 0, 0), O_IDLE};
        tbl[6] = '{mk(5, 2, 0, 5, 1, 1, 0, 0), O_REDIR};
        tbl[7] = '{mk(0, 0, 0, 0, 0, 1, 0, 0), O_REDIR};
        tbl[8] = '{mk(9, 9, 1, 9, 1, 0, 0, 0), O_STALL};
        tbl[9] = '{mk(3, 4, 1, 6, 1, 0, 0, 1), O_IDLE};
        for (int k = 0; k < 10; k++) begin
            cur = tbl[k].in;
            #2;
            compare($sformatf("tbl%0d", k), 32'(outs_a()), 32'(tbl[k].exp));
            #(-2 + 2);
            @(posedge clk);
            ma = model_step(ma, cur, rst);
            mb = model_step(mb, cur, rst);
            #1;
        end

        // Single-cycle load-use hazard: 1 stall at LAT=1, 3 stalls at LAT=3.
        do_reset();
        cur = mk(5, 0, 0, 5, 1, 0, 0, 0);
        cycle("lu0");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle("lu");
        compare("lu_low_a", 32'(low_a), 32'd1);
        compare("lu_low_b", 32'(low_b), 32'd3);
        compare("lu_bub_b", 32'(bub_b), 32'd3);
        compare("lu_cnt_a", 32'(bus_a.stall_cycles), 32'd1);
        compare("lu_cnt_b", 32'(bus_b.stall_cycles), 32'd3);

        // Redirect on the second load-stall cycle: two flush cycles with PC advancing.
        do_reset();
        cur = mk(5, 0, 0, 5, 1, 0, 0, 0);
        cycle("rd_hz");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rd_ls1");
        cur = mk(0, 0, 0, 0, 0, 1, 0, 0);
        cycle("rd_pc");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rd_fl");
        #2;
        compare("rd_run_b", 32'(outs_b()), 32'(O_IDLE));
        #(-2 + 2);
        cycle("rd_run");
        compare("rd_flush_b", 32'(flush_b), 32'd2);
        compare("rd_flushpc_b", 32'(flushpc_b), 32'd2);

        // brk together with pc_src halts; brk/pc_src ignored in HALT; resume releases.
        cur = mk(0, 0, 0, 0, 0, 1, 1, 0);
        cycle("bk0");
        #2;
        compare("bk_halt_a", 32'({bus_a.halted, bus_a.pc_write}), 32'b10);
        compare("bk_halt_b", 32'({bus_b.halted, bus_b.pc_write}), 32'b10);
        #(-2 + 2);
        cycle("bk1");
        cur = mk(0, 0, 0, 0, 0, 0, 1, 1);
        cycle("bk_res");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        compare("bk_run_a", 32'(outs_a()), 32'(O_IDLE));
        #(-2 + 2);
        cycle("bk_after");

        // Saturation of the 4-bit stall counter under a permanent hazard.
        do_reset();
        cur = mk(5, 0, 0, 5, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle("sat");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        compare("sat_cnt_a", 32'(bus_a.stall_cycles), 32'd20);
        compare("sat_cnt_b", 32'(bus_b.stall_cycles), 32'd15);
        #(-2 + 2);
        cycle("sat_idle");

        // Asynchronous reset in the middle of a load stall.
        cur = mk(5, 0, 0, 5, 1, 0, 0, 0);
        cycle("ar_hz");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        compare("ar_out_a", 32'(outs_a()), 32'(O_RST));
        compare("ar_out_b", 32'(outs_b()), 32'(O_RST));
        compare("ar_cnt_a", 32'(bus_a.stall_cycles), 32'd0);
        compare("ar_cnt_b", 32'(bus_b.stall_cycles), 32'd0);
        @(posedge clk);
        ma = model_step(ma, cur, rst);
        mb = model_step(mb, cur, rst);
        #1;
        rst = 1'b0;
        #2;
        compare("ar_run_b", 32'(outs_b()), 32'(O_IDLE));
        #(-2 + 2);
        cycle("ar_run");

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cur.rs       = 5'($urandom_range(0, 3));
            cur.rt       = 5'($urandom_range(0, 3));
            cur.ex_rt    = 5'($urandom_range(0, 3));
            cur.uses_rt  = 1'($urandom_range(0, 1));
            cur.mem_read = 1'($urandom_range(0, 1));
            cur.pc_src   = ($urandom_range(0, 7) == 0);
            cur.brk      = ($urandom_range(0, 31) == 0);
            cur.resume   = ($urandom_range(0, 3) == 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..4, load-use stall cycles.
REQ-003 SHALL have parameter FLUSH_DEPTH, default 1, range 1..3, IF/ID flush cycles per redirect.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the following remaining ports:
- if_id_rs  in  REG_W  ID-stage source register 1.
- if_id_rt  in  REG_W  ID-stage source register 2.
- if_id_uses_rt  in  1  ID instruction reads rt.
- id_ex_rt  in  REG_W  EX-stage load destination.
- id_ex_mem_read  in  1  EX-stage instruction is a load.
- pc_src  in  1  taken branch/jump redirect.
- brk  in  1  break request.
- resume  in  1  leave halt (pulse).
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_bubble  out  1  ID/EX control zeroing.
- ex_mem_bubble  out  1  EX/MEM control zeroing.
- halted  out  1  core halted.
- stall_cycles  out  CNT_W  saturating stall count.

Function
REQ-007 SHALL implement FSM states RUN, LSTALL, FLUSH, HALT; outputs are combinational from state and inputs.
REQ-008 SHALL define hazard = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt))); register 0 never stalls.
REQ-009 In RUN, priority SHALL be brk > pc_src > hazard > idle.
REQ-010 In RUN with no event, outputs SHALL be: pc_write=1, if_id_write=1, all flush/bubble=0.
REQ-011 In RUN with hazard, outputs SHALL be: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, same cycle.
REQ-012 On hazard, if LOAD_LAT>1, the FSM SHALL enter LSTALL with cnt=LOAD_LAT-1; otherwise it SHALL stay in RUN.
REQ-013 LSTALL SHALL drive the same outputs as REQ-011, decrement cnt each cycle, and go to RUN the cycle after cnt reaches 1.
REQ-014 On pc_src in RUN or LSTALL, outputs SHALL be: pc_write=1, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1.
REQ-015 On pc_src, if FLUSH_DEPTH>1, the FSM SHALL enter FLUSH with cnt=FLUSH_DEPTH-1; otherwise it SHALL go to RUN. Any LSTALL is abandoned.
REQ-016 FLUSH SHALL drive pc_write=1, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=0, and return to RUN after cnt expires.
REQ-017 pc_src in FLUSH SHALL reload cnt=FLUSH_DEPTH-1.
REQ-018 brk in RUN, LSTALL or FLUSH SHALL drive the REQ-014 outputs except pc_write=0, then enter HALT.
REQ-019 HALT SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, ex_mem_bubble=0, halted=1.
REQ-020 In HALT, brk and pc_src SHALL be ignored; resume SHALL go to RUN next cycle.
REQ-021 halted SHALL be 1 only in HALT.
REQ-022 stall_cycles SHALL increment on each cycle with pc_write=0 outside HALT and rst, and SHALL saturate at 2^CNT_W-1.

Reset
REQ-023 rst SHALL asynchronously force state=RUN, cnt=0, stall_cycles=0.
REQ-024 While rst=1, outputs SHALL be: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, halted=0.
REQ-025 On reset release, outputs SHALL follow RUN behaviour in the first cycle.
REQ-026 Reset during any state SHALL abort it with no residual stall.

Structure
REQ-027 Package hazard_pkg SHALL hold the state enum, the LOAD_LAT and FLUSH_DEPTH maxima, and the counter width derived from them.
REQ-028 A sub-module sat_counter (CNT_W, enable, saturating) SHALL implement stall_cycles.

Verification
REQ-029 LOAD_LAT=1, id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 for one cycle -> pc_write=0 for 1 cycle, stall_cycles=1.
REQ-030 LOAD_LAT=3, same hazard -> pc_write=0, id_ex_bubble=1 for exactly 3 cycles; stall_cycles=3.
REQ-031 id_ex_rt=0=if_id_rs with load; and id_ex_rt=7=if_id_rt with if_id_uses_rt=0 -> no stall in either case.
REQ-032 FLUSH_DEPTH=2, pc_src during LSTALL cycle 2 -> if_id_flush=1 for 2 cycles, pc_write=1, then RUN.
REQ-033 brk and pc_src simultaneously -> HALT, halted=1, pc_write=0; resume+brk in HALT -> RUN next cycle.
REQ-034 rst asserted mid-LSTALL and CNT_W=4 saturation (20 stall cycles -> stall_cycles=15) -> outputs per REQ-024, counters cleared.
